execute_mem_dcache_refill: RTL and testbench

Line-refill engine for the execute-stage data cache: the writer side of the cache's tag-update and data-update ports. On a load miss it takes one miss request, invalidates the target line's tag, fetches the 32-byte line (8 × 32-bit words) from memory over an AXI4 read burst, and streams each beat into the data array under the cache's update_data_ready backpressure. It then writes the tag valid and reports completion. It sits between the LSU miss logic and the core's AXI read master port.

---
 rtl/execute_mem_dcache_refill_if.sv | 48 ++++
 rtl/execute_mem_dcache_refill.sv | 110 +++++++++++
 tb/tb_execute_mem_dcache_refill.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/execute_mem_dcache_refill_if.sv
// Bundle between the refill engine, LSU miss logic, AXI read master and cache update ports.
// master = refill engine side, slave = surrounding environment.
interface execute_mem_dcache_refill_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        busy_valid;
  logic [26:0] busy_line;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_rvalid;
  logic        m_rready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic        update_tag_en;
  logic [31:0] update_tag_addr;
  logic        update_tag_valid;
  logic        update_data_valid;
  logic [31:0] update_data_addr;
  logic [3:0]  update_data_strb;
  logic [31:0] update_data;
  logic        update_data_ready;
  logic        done_valid;
  logic        done_err;

  modport master (
    input  req_valid, req_addr, m_arready, m_rvalid, m_rdata, m_rresp, m_rlast,
           update_data_ready,
    output req_ready, busy_valid, busy_line, m_arvalid, m_araddr, m_arlen, m_arsize,
           m_arburst, m_rready, update_tag_en, update_tag_addr, update_tag_valid,
           update_data_valid, update_data_addr, update_data_strb, update_data,
           done_valid, done_err
  );

  modport slave (
    output req_valid, req_addr, m_arready, m_rvalid, m_rdata, m_rresp, m_rlast,
           update_data_ready,
    input  req_ready, busy_valid, busy_line, m_arvalid, m_araddr, m_arlen, m_arsize,
           m_arburst, m_rready, update_tag_en, update_tag_addr, update_tag_valid,
           update_data_valid, update_data_addr, update_data_strb, update_data,
           done_valid, done_err
  );
endinterface

// File: rtl/execute_mem_dcache_refill.sv
// D-cache line refill: invalidate tag, 8-beat AXI read burst streamed into the data array, write tag.
// Minimum 13 cycles per line; update_data_ready low stalls the R channel one cycle per cycle low.
module execute_mem_dcache_refill (
  input  logic                               clk,
  input  logic                               resetn,
  execute_mem_dcache_refill_if.master        bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INV,
    S_AR,
    S_R,
    S_TAG,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [26:0] line_q, line_d;
  logic [2:0]  beat_q, beat_d;
  logic        err_q, err_d;
  logic        beat_xfer;
  logic        resp_err;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      line_q  <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  assign beat_xfer = (state_q == S_R) && bus.m_rvalid && bus.update_data_ready;
  assign resp_err  = bus.m_rresp inside {2'b10, 2'b11};

  always_comb begin
    state_d                = state_q;
    line_d                 = line_q;
    beat_d                 = beat_q;
    err_d                  = err_q;
    bus.req_ready          = 1'b0;
    bus.m_arvalid          = 1'b0;
    bus.m_rready           = 1'b0;
    bus.update_tag_en      = 1'b0;
    bus.update_tag_valid   = 1'b0;
    bus.update_data_valid  = 1'b0;
    bus.update_data        = '0;
    bus.done_valid         = 1'b0;
    bus.done_err           = 1'b0;

    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          line_d  = 27'(bus.req_addr >> 5);
          beat_d  = '0;
          err_d   = 1'b0;
          state_d = S_INV;
        end
      end
      S_INV: begin
        // Kill the tag before any data lands so the line cannot hit mid-refill.
        bus.update_tag_en = 1'b1;
        state_d           = S_AR;
      end
      S_AR: begin
        bus.m_arvalid = 1'b1;
        if (bus.m_arready) state_d = S_AR == S_AR ? S_R : S_AR;
      end
      S_R: begin
        bus.m_rready          = bus.update_data_ready;
        bus.update_data_valid = bus.m_rvalid;
        bus.update_data       = bus.m_rdata;
        if (beat_xfer) begin
          beat_d = beat_q + 3'd1;
          if (resp_err || (bus.m_rlast && beat_q != 3'd7)) err_d = 1'b1;
          if (bus.m_rlast) state_d = S_TAG;
        end
      end
      S_TAG: begin
        bus.update_tag_en    = 1'b1;
        bus.update_tag_valid = ~err_q;
        state_d              = S_DONE;
      end
      S_DONE: begin
        bus.done_valid = 1'b1;
        bus.done_err   = err_q;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy_valid       = (state_q != S_IDLE);
  assign bus.busy_line        = line_q;
  assign bus.m_araddr         = {line_q, 5'b0};
  assign bus.m_arlen          = 8'd7;
  assign bus.m_arsize         = 3'd2;
  assign bus.m_arburst        = 2'b01;
  assign bus.update_tag_addr  = {line_q, 5'b0};
  assign bus.update_data_addr = {line_q, beat_q, 2'b00};
  assign bus.update_data_strb = 4'hF;

endmodule

// File: tb/tb_execute_mem_dcache_refill.sv
// Bench for the refill engine: cycle-by-cycle vector table for a clean refill, then
// hand-sequenced stall, AR delay, error, early-rlast and mid-refill reset scenarios.
module tb_execute_mem_dcache_refill;

  logic clk = 1'b0;
  logic resetn;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  execute_mem_dcache_refill_if bus_if ();

  execute_mem_dcache_refill dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_if.master)
  );

  typedef struct {
    logic        rv;
    logic [31:0] ra;
    logic        arr;
    logic        rvld;
    logic [31:0] rd;
    logic [1:0]  rsp;
    logic        rl;
    logic        udr;
    logic [8:0]  fl;
    logic [31:0] da;
    logic [31:0] dd;
  } vec_t;

  vec_t tbl [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] flags();
    return {bus_if.req_ready, bus_if.busy_valid, bus_if.m_arvalid, bus_if.m_rready,
            bus_if.update_tag_en, bus_if.update_tag_valid, bus_if.update_data_valid,
            bus_if.done_valid, bus_if.done_err};
  endfunction

  task automatic idle_inputs();
    bus_if.req_valid         = 1'b0;
    bus_if.req_addr          = '0;
    bus_if.m_arready         = 1'b0;
    bus_if.m_rvalid          = 1'b0;
    bus_if.m_rdata           = '0;
    bus_if.m_rresp           = '0;
    bus_if.m_rlast           = 1'b0;
    bus_if.update_data_ready = 1'b1;
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, " flags"}, 64'(flags()), 64'(9'b1_0000_0000));
    chk({nm, " araddr"}, 64'(bus_if.m_araddr), 64'h0);
    chk({nm, " data_addr"}, 64'(bus_if.update_data_addr), 64'h0);
    chk({nm, " tag_addr"}, 64'(bus_if.update_tag_addr), 64'h0);
    chk({nm, " data"}, 64'(bus_if.update_data), 64'h0);
    chk({nm, " busy_line"}, 64'(bus_if.busy_line), 64'h0);
  endtask

  // Drives one refill as memory + cache, checking each beat against the bench's own beat count.
  task automatic refill(input logic [31:0] addr, input int ar_dly, input int stall_beat,
                        input int stall_len, input int err_beat, input int last_beat,
                        input int exp_done, input logic exp_err, input string nm);
    int          b = 0, st = 0, ar_cnt = 0, done_c = -1, stray = 0;
    logic        ar_done = 1'b0, last_sent = 1'b0, done_e = 1'b0, ar_ok = 1'b1;
    logic [31:0] base;
    base = {addr[31:5], 5'b0};
    for (int c = 0; c < 60 && done_c < 0; c++) begin
      bus_if.req_valid         = (c == 0);
      bus_if.req_addr          = addr;
      bus_if.m_arready         = bus_if.m_arvalid && (ar_cnt == ar_dly);
      bus_if.m_rvalid          = ar_done && !last_sent;
      bus_if.m_rdata           = 32'(32'hA0 + b);
      bus_if.m_rresp           = (b == err_beat) ? 2'b10 : 2'b00;
      bus_if.m_rlast           = (b == last_beat);
      bus_if.update_data_ready = !(b == stall_beat && st < stall_len);
      #1;
      if (bus_if.m_arvalid && (bus_if.m_araddr !== base || bus_if.m_arlen !== 8'd7))
        ar_ok = 1'b0;
      if (c == 1)
        chk({nm, " tag_inv"}, 64'({bus_if.update_tag_en, bus_if.update_tag_valid}), 64'b10);
      else if (c == exp_done - 1)
        chk({nm, " tag_final"}, 64'({bus_if.update_tag_en, bus_if.update_tag_valid}),
            64'({1'b1, !exp_err}));
      else if (bus_if.update_tag_en)
        stray++;
      if (bus_if.m_rvalid && !bus_if.update_data_ready) begin
        chk({nm, " stall_rready"}, 64'(bus_if.m_rready), 64'h0);
        chk({nm, " stall_addr"}, 64'(bus_if.update_data_addr), 64'(32'(base + 4 * b)));
        st++;
      end
      if (bus_if.m_rvalid && bus_if.update_data_ready) begin
        chk({nm, " beat_addr"}, 64'(bus_if.update_data_addr), 64'(32'(base + 4 * b)));
        chk({nm, " beat_data"}, 64'({bus_if.update_data_valid, bus_if.update_data}),
            64'({1'b1, 32'(32'hA0 + b)}));
        last_sent = bus_if.m_rlast;
        b++;
      end
      if (bus_if.done_valid) begin
        done_c = c;
        done_e = bus_if.done_err;
      end
      if (bus_if.m_arvalid) begin
        if (bus_if.m_arready) ar_done = 1'b1;
        ar_cnt++;
      end
      tick();
    end
    idle_inputs();
    #1;
    chk({nm, " ready_after"}, 64'({bus_if.req_ready, bus_if.busy_valid}), 64'b10);
    chk({nm, " beats"}, 64'(b), 64'(last_beat + 1));
    chk({nm, " done_cycle"}, 64'(done_c), 64'(exp_done));
    chk({nm, " done_err"}, 64'(done_e), 64'(exp_err));
    chk({nm, " stray_tag"}, 64'(stray), 64'h0);
    chk({nm, " ar_stable"}, 64'(ar_ok), 64'h1);
    tick();
  endtask

  initial begin
    // Clean refill of 0x0001_2344, one record per cycle from acceptance.
    tbl[0]  = '{1'b1, 32'h0001_2344, 1'b0, 1'b0, 32'h0, 2'b0, 1'b0, 1'b1, 9'b100000000, 32'h0, 32'h0};
    tbl[1]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b0, 1'b0, 1'b1, 9'b010010000, 32'h0001_2340, 32'h0};
    tbl[2]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b0, 1'b0, 1'b1, 9'b011000000, 32'h0001_2340, 32'h0};
    for (int k = 0; k < 8; k++)
      tbl[3+k] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'(32'hA0 + k), 2'b0, (k == 7), 1'b1,
                   9'b010100100, 32'(32'h0001_2340 + 4 * k), 32'(32'hA0 + k)};
    tbl[11] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b0, 1'b0, 1'b1, 9'b010011000, 32'h0001_2340, 32'h0};
    tbl[12] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b0, 1'b0, 1'b1, 9'b010000010, 32'h0001_2340, 32'h0};
    tbl[13] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b0, 1'b0, 1'b1, 9'b100000000, 32'h0001_2340, 32'h0};

    resetn = 1'b0;
    idle_inputs();
    repeat (3) tick();
    check_reset_outputs("reset");
    resetn = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) begin
      bus_if.req_valid         = tbl[i].rv;
      bus_if.req_addr          = tbl[i].ra;
      bus_if.m_arready         = tbl[i].arr;
      bus_if.m_rvalid          = tbl[i].rvld;
      bus_if.m_rdata           = tbl[i].rd;
      bus_if.m_rresp           = tbl[i].rsp;
      bus_if.m_rlast           = tbl[i].rl;
      bus_if.update_data_ready = tbl[i].udr;
      #1;
      chk($sformatf("vec%0d", i), 64'({flags(), bus_if.update_data_addr, bus_if.update_data}),
          64'({tbl[i].fl, tbl[i].da, tbl[i].dd}));
      if (i == 2)
        chk("ar_fields", 64'({bus_if.m_araddr, bus_if.m_arlen, bus_if.m_arsize,
                               bus_if.m_arburst, bus_if.update_data_strb}),
            64'({32'h0001_2340, 8'd7, 3'd2, 2'b01, 4'hF}));
      tick();
    end
    idle_inputs();

    refill(32'h0001_2344, 0, 99, 0, 99, 7, 12, 1'b0, "clean");
    refill(32'h0001_2344, 0, 4, 3, 99, 7, 15, 1'b0, "stall");
    refill(32'h0004_0000, 5, 99, 0, 99, 7, 17, 1'b0, "ar_stall");
    refill(32'h0000_1000, 0, 99, 0, 2, 7, 12, 1'b1, "slverr");
    refill(32'h0000_2000, 0, 99, 0, 99, 5, 10, 1'b1, "early_last");

    // Reset while beat 3 is on the R channel.
    bus_if.req_valid = 1'b1;
    bus_if.req_addr  = 32'h0003_0040;
    tick();
    bus_if.req_valid = 1'b0;
    tick();
    bus_if.m_arready = 1'b1;
    tick();
    bus_if.m_arready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus_if.m_rvalid = 1'b1;
      bus_if.m_rdata  = 32'(32'hA0 + k);
      if (k == 3) resetn = 1'b0;
      tick();
    end
    resetn = 1'b1;
    idle_inputs();
    #1;
    check_reset_outputs("mid_reset");
    tick();
    refill(32'h8000_0FE4, 0, 99, 0, 99, 7, 12, 1'b0, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
